// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        LAP     = 2'd3
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
    } sw_time_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t MIN_TENS_MAX = 4'd5;
    localparam bcd_t ONES_MAX     = 4'd9;

    // Increment one BCD digit, wrapping to 0 after max.
    function automatic bcd_t bcd_next(input bcd_t d, input bcd_t max);
        return (d == max) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes one raw button, debounces it on ms ticks and emits a press pulse.
// Latency: 2 sync flops, then DEBOUNCE_MS stable ticks; press is 1 cycle after the accepting tick.
// Backpressure: none; press is a fire-and-forget single-cycle pulse.
module button_debouncer
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_MS = 20,
    parameter int DBC_W       = 5
) (
    input  logic clk_25MHz,
    input  logic rst_n,
    input  logic ms_tick,
    input  logic btn_raw,
    output logic press
);

    logic             btn_s1;
    logic             btn_s2;
    logic             level;
    logic [DBC_W-1:0] cnt;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
        end
    end

    // Stability counter and accepted level; press fires only on an accepted 0->1.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (ms_tick) begin
                if (btn_s2 != level) begin
                    if (cnt == DBC_W'(DEBOUNCE_MS - 1)) begin
                        level <= btn_s2;
                        cnt   <= '0;
                        press <= btn_s2;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch sequencing: 1 kHz tick extraction, button debounce, run/pause/lap FSM, mm:ss BCD count.
// Latency: ms_tick 3 cycles after the 1 kHz rising edge; digits registered 1 cycle after count/state.
// Backpressure: none; every tick and button event is consumed in the cycle it occurs.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000,
    parameter int DEBOUNCE_MS   = 20,
    parameter int DBC_W         = 5
) (
    input  logic       clk_25MHz,
    input  logic       rst_n,
    input  logic       clk_1kHz,
    input  logic       btn_start_stop,
    input  logic       btn_lap,
    input  logic       btn_reset,
    output logic       running,
    output logic       lap_active,
    output logic       overflow,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones
);

    // A 1-bit counter still works when only one tick makes a second.
    localparam int MS_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [MS_W-1:0] MS_MAX = MS_W'(TICKS_PER_SEC - 1);

    logic            k_s1;
    logic            k_s2;
    logic            k_s3;
    logic            ms_tick;
    logic            ss_ev;
    logic            lap_ev;
    logic            rst_ev;
    sw_state_t       state;
    sw_state_t       state_nxt;
    logic            counting;
    logic            clear_cnt;
    logic            capture_lap;
    logic [MS_W-1:0] ms_cnt;
    sw_time_t        live;
    sw_time_t        lap_time;
    sw_time_t        disp;

    // Synchronize the divided clock and register its rising edge as a one-cycle tick.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            k_s1    <= 1'b0;
            k_s2    <= 1'b0;
            k_s3    <= 1'b0;
            ms_tick <= 1'b0;
        end else begin
            k_s1    <= clk_1kHz;
            k_s2    <= k_s1;
            k_s3    <= k_s2;
            ms_tick <= k_s2 & ~k_s3;
        end
    end

    button_debouncer #(.DEBOUNCE_MS(DEBOUNCE_MS), .DBC_W(DBC_W)) u_dbc_ss (
        .clk_25MHz (clk_25MHz),
        .rst_n     (rst_n),
        .ms_tick   (ms_tick),
        .btn_raw   (btn_start_stop),
        .press     (ss_ev)
    );

    button_debouncer #(.DEBOUNCE_MS(DEBOUNCE_MS), .DBC_W(DBC_W)) u_dbc_lap (
        .clk_25MHz (clk_25MHz),
        .rst_n     (rst_n),
        .ms_tick   (ms_tick),
        .btn_raw   (btn_lap),
        .press     (lap_ev)
    );

    button_debouncer #(.DEBOUNCE_MS(DEBOUNCE_MS), .DBC_W(DBC_W)) u_dbc_rst (
        .clk_25MHz (clk_25MHz),
        .rst_n     (rst_n),
        .ms_tick   (ms_tick),
        .btn_raw   (btn_reset),
        .press     (rst_ev)
    );

    // FSM state register.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and side-effect strobes; start_stop takes priority over lap and reset.
    always_comb begin
        state_nxt   = state;
        clear_cnt   = 1'b0;
        capture_lap = 1'b0;
        unique case (state)
            IDLE: begin
                if (ss_ev) state_nxt = RUNNING;
            end
            RUNNING: begin
                if (ss_ev) begin
                    state_nxt = PAUSED;
                end else if (lap_ev) begin
                    state_nxt   = LAP;
                    capture_lap = 1'b1;
                end
            end
            LAP: begin
                if (ss_ev)       state_nxt = PAUSED;
                else if (lap_ev) state_nxt = RUNNING;
            end
            PAUSED: begin
                if (ss_ev) begin
                    state_nxt = RUNNING;
                end else if (rst_ev) begin
                    state_nxt = IDLE;
                    clear_cnt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counting uses the pre-transition state so a tick coinciding with a stop still counts.
    assign counting = (state == RUNNING) || (state == LAP);

    // Millisecond counter, BCD carry chain and sticky overflow.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            ms_cnt   <= '0;
            live     <= '0;
            overflow <= 1'b0;
        end else if (clear_cnt) begin
            ms_cnt   <= '0;
            live     <= '0;
            overflow <= 1'b0;
        end else if (ms_tick && counting) begin
            if (ms_cnt == MS_MAX) begin
                ms_cnt        <= '0;
                live.sec_ones <= bcd_next(live.sec_ones, ONES_MAX);
                if (live.sec_ones == ONES_MAX) begin
                    live.sec_tens <= bcd_next(live.sec_tens, SEC_TENS_MAX);
                    if (live.sec_tens == SEC_TENS_MAX) begin
                        live.min_ones <= bcd_next(live.min_ones, ONES_MAX);
                        if (live.min_ones == ONES_MAX) begin
                            live.min_tens <= bcd_next(live.min_tens, MIN_TENS_MAX);
                            if (live.min_tens == MIN_TENS_MAX) begin
                                overflow <= 1'b1;
                            end
                        end
                    end
                end
            end else begin
                ms_cnt <= ms_cnt + 1'b1;
            end
        end
    end

    // Lap latch snapshots the live count as the FSM enters LAP.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            lap_time <= '0;
        end else if (capture_lap) begin
            lap_time <= live;
        end
    end

    // Registered display: frozen lap value in LAP, live count otherwise.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            disp <= '0;
        end else begin
            disp <= (state == LAP) ? lap_time : live;
        end
    end

    assign running    = counting;
    assign lap_active = (state == LAP);
    assign min_tens   = disp.min_tens;
    assign min_ones   = disp.min_ones;
    assign sec_tens   = disp.sec_tens;
    assign sec_ones   = disp.sec_ones;

endmodule

// File: tb/tb_stopwatch_controller.sv
module tb_stopwatch_controller;

    logic       clk_25MHz = 1'b0;
    logic       rst_n     = 1'b0;
    logic       clk_1kHz  = 1'b0;
    logic [2:0] btn_a     = 3'b000;   // {reset, lap, start_stop} for the TPS=10 unit
    logic [2:0] btn_b     = 3'b000;   // same for the TPS=1 rollover unit

    logic       run_a, lap_a, ovf_a;
    logic [3:0] mt_a, mo_a, st_a, so_a;
    logic       run_b, lap_b, ovf_b;
    logic [3:0] mt_b, mo_b, st_b, so_b;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk_25MHz = ~clk_25MHz;

    stopwatch_controller #(.TICKS_PER_SEC(10), .DEBOUNCE_MS(2), .DBC_W(5)) dut (
        .clk_25MHz      (clk_25MHz),
        .rst_n          (rst_n),
        .clk_1kHz       (clk_1kHz),
        .btn_start_stop (btn_a[0]),
        .btn_lap        (btn_a[1]),
        .btn_reset      (btn_a[2]),
        .running        (run_a),
        .lap_active     (lap_a),
        .overflow       (ovf_a),
        .min_tens       (mt_a),
        .min_ones       (mo_a),
        .sec_tens       (st_a),
        .sec_ones       (so_a)
    );

    stopwatch_controller #(.TICKS_PER_SEC(1), .DEBOUNCE_MS(2), .DBC_W(5)) dut_ro (
        .clk_25MHz      (clk_25MHz),
        .rst_n          (rst_n),
        .clk_1kHz       (clk_1kHz),
        .btn_start_stop (btn_b[0]),
        .btn_lap        (btn_b[1]),
        .btn_reset      (btn_b[2]),
        .running        (run_b),
        .lap_active     (lap_b),
        .overflow       (ovf_b),
        .min_tens       (mt_b),
        .min_ones       (mo_b),
        .sec_tens       (st_b),
        .sec_ones       (so_b)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One 1 kHz period (5 high, 5 low cycles): yields exactly one ms tick inside it.
    task automatic one_ms();
        @(negedge clk_25MHz) clk_1kHz = 1'b1;
        repeat (5) @(negedge clk_25MHz);
        clk_1kHz = 1'b0;
        repeat (4) @(negedge clk_25MHz);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) one_ms();
    endtask

    // Hold buttons for 2 ticks (accepted on the 2nd), then release for 2 ticks.
    task automatic press(input bit ro, input logic [2:0] mask);
        if (ro) btn_b = mask; else btn_a = mask;
        ticks(2);
        if (ro) btn_b = 3'b000; else btn_a = 3'b000;
        ticks(2);
    endtask

    initial begin
        // Reset held with the 1 kHz input toggling.
        rst_n = 1'b0;
        ticks(3);
        @(negedge clk_25MHz) rst_n = 1'b1;
        repeat (3) @(negedge clk_25MHz);
        chk("rst_time",    {mt_a, mo_a, st_a, so_a}, 16'h0000);
        chk("rst_running", 16'(run_a), 16'd0);
        chk("rst_lap",     16'(lap_a), 16'd0);
        chk("rst_ovf",     16'(ovf_a), 16'd0);

        // lap and reset ignored in IDLE.
        press(1'b0, 3'b010);
        press(1'b0, 3'b100);
        chk("idle_ign_time", {mt_a, mo_a, st_a, so_a}, 16'h0000);
        chk("idle_ign_run",  16'(run_a), 16'd0);

        // Start: 2 counted press-release ticks + 23 = 25 ticks -> 00:02 residue 5.
        press(1'b0, 3'b001);
        ticks(23);
        chk("start_time", {mt_a, mo_a, st_a, so_a}, 16'h0002);
        chk("start_run",  16'(run_a), 16'd1);

        // Pause: 2 more ticks count (residue 7), then frozen.
        press(1'b0, 3'b001);
        chk("pause_run",  16'(run_a), 16'd0);
        ticks(100);
        chk("pause_hold", {mt_a, mo_a, st_a, so_a}, 16'h0002);

        // Resume: 2 counted release ticks + 5 -> total 34 ticks = 00:03.
        press(1'b0, 3'b001);
        ticks(5);
        chk("resume_time", {mt_a, mo_a, st_a, so_a}, 16'h0003);
        chk("resume_run",  16'(run_a), 16'd1);

        // 6 more ticks -> 40 = 00:04 exactly.
        ticks(6);
        chk("at_4s", {mt_a, mo_a, st_a, so_a}, 16'h0004);

        // Lap: captures 00:04 (total 44 after press), display frozen while counting.
        press(1'b0, 3'b010);
        chk("lap_active", 16'(lap_a), 16'd1);
        chk("lap_run",    16'(run_a), 16'd1);
        chk("lap_frozen", {mt_a, mo_a, st_a, so_a}, 16'h0004);
        ticks(30);
        chk("lap_frozen_3s", {mt_a, mo_a, st_a, so_a}, 16'h0004);
        press(1'b0, 3'b010);
        chk("lap_exit_time", {mt_a, mo_a, st_a, so_a}, 16'h0007);
        chk("lap_exit_flag", 16'(lap_a), 16'd0);

        // Glitch: 1 tick high then 1 tick low -> no event (total 80 = 00:08).
        btn_a = 3'b001;
        one_ms();
        btn_a = 3'b000;
        one_ms();
        chk("glitch_run",  16'(run_a), 16'd1);
        chk("glitch_time", {mt_a, mo_a, st_a, so_a}, 16'h0008);

        // Clean press -> single event to PAUSED; release produces nothing.
        press(1'b0, 3'b001);
        ticks(3);
        chk("db_pause_run",  16'(run_a), 16'd0);
        chk("db_pause_time", {mt_a, mo_a, st_a, so_a}, 16'h0008);

        // start_stop + reset together while PAUSED -> RUNNING, count kept (84).
        press(1'b0, 3'b101);
        chk("prio_run",  16'(run_a), 16'd1);
        chk("prio_time", {mt_a, mo_a, st_a, so_a}, 16'h0008);

        // Reset while RUNNING ignored: 4 + 2 ticks -> 90 = 00:09.
        press(1'b0, 3'b100);
        ticks(2);
        chk("rst_ign_run",  16'(run_a), 16'd1);
        chk("rst_ign_time", {mt_a, mo_a, st_a, so_a}, 16'h0009);

        // Rollover unit, 1 tick per second: start gives 2 s, then 3597 -> 59:59.
        press(1'b1, 3'b001);
        ticks(3597);
        chk("ro_5959",     {mt_b, mo_b, st_b, so_b}, 16'h5959);
        chk("ro_ovf_pre",  16'(ovf_b), 16'd0);
        one_ms();
        chk("ro_wrap",     {mt_b, mo_b, st_b, so_b}, 16'h0000);
        chk("ro_ovf",      16'(ovf_b), 16'd1);

        // Pause (2 counted ticks -> 00:02), overflow stays sticky, then reset to IDLE.
        press(1'b1, 3'b001);
        chk("ro_pause_time", {mt_b, mo_b, st_b, so_b}, 16'h0002);
        chk("ro_pause_ovf",  16'(ovf_b), 16'd1);
        press(1'b1, 3'b100);
        chk("ro_clr_time", {mt_b, mo_b, st_b, so_b}, 16'h0000);
        chk("ro_clr_ovf",  16'(ovf_b), 16'd0);
        chk("ro_clr_run",  16'(run_b), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/stopwatch_controller.md
Name: stopwatch_controller

Overview:
Sequencing controller for the stopwatch. Consumes the divided 1 kHz clock as a data signal and converts it into a single-cycle millisecond tick in the 25 MHz domain. Debounces the three user buttons and runs the start/stop/lap/reset state machine. Keeps the mm:ss BCD count and drives the display digits, either live or lap-frozen.

Parameters:
TICKS_PER_SEC, 1000, ms ticks per counted second (set small in simulation)
DEBOUNCE_MS, 20, consecutive stable ms ticks before a button level is accepted
DBC_W, 5, debounce counter width; must satisfy 2**DBC_W > DEBOUNCE_MS

Ports:
clk_25MHz  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
clk_1kHz  input  1  divided 1 kHz square wave, sampled as data (asynchronous to this logic)
btn_start_stop  input  1  raw button, active-high
btn_lap  input  1  raw button, active-high
btn_reset  input  1  raw button, active-high
running  output  1  high in RUNNING or LAP
lap_active  output  1  high in LAP (display frozen)
overflow  output  1  sticky; set on wrap 59:59 -> 00:00
min_tens, min_ones, sec_tens, sec_ones  output  4 each  displayed BCD digits

Behaviour:
- Reset (async assert, sync release): state IDLE; all counters, digits, the lap latch and overflow are 0; running=0, lap_active=0; synchronizers are 0.
- ms_tick:
  - clk_1kHz passes through a 2-flop synchronizer, then a rising-edge detect.
  - ms_tick is a 1-cycle pulse, 3 clk_25MHz cycles after the input edge.
- Debounce, per button, on ms_tick only:
  - Raw inputs are 2-flop synchronized.
  - If the synced value differs from the accepted level, the counter increments; otherwise the counter clears.
  - When the counter reaches DEBOUNCE_MS, the accepted level updates and the counter clears.
  - A press event is a 1-cycle pulse on the 0->1 edge of the accepted level. Release produces no event.
- FSM states: IDLE, RUNNING, PAUSED, LAP.
  - IDLE: start_stop -> RUNNING. lap and reset are ignored.
  - RUNNING: start_stop -> PAUSED. lap -> LAP, capturing the live digits into the lap latch in the same cycle. reset is ignored.
  - LAP: start_stop -> PAUSED (display returns to live). lap -> RUNNING (display returns to live). reset is ignored.
  - PAUSED: start_stop -> RUNNING. reset -> IDLE and clears the ms counter, all digits and overflow. lap is ignored.
  - Simultaneous events in one cycle: start_stop wins over lap and reset.
- Counting (on ms_tick, only in RUNNING or LAP):
  - The ms counter runs 0..TICKS_PER_SEC-1; its wrap increments sec_ones.
  - BCD carry chain: sec_ones 9->0 carries to sec_tens; sec_tens 5->0 carries to min_ones; min_ones 9->0 carries to min_tens; min_tens 5->0.
  - 59:59 plus 1 s wraps to 00:00 and sets overflow (sticky until reset->IDLE).
  - PAUSED freezes the ms counter, so the sub-second residue is kept; resume continues from it.
- Display: digit outputs are registered. They show the lap latch in LAP and the live count otherwise, with 1 cycle latency from count or state change.
- A state change coincident with ms_tick: the tick is evaluated using the state before the transition. A tick in the cycle RUNNING->PAUSED still counts; a tick in the cycle PAUSED->RUNNING does not.
- Reset asserted mid-count: immediate return to the reset values; no partial carry survives.

Decomposition:
- stopwatch_pkg:
  - state enum sw_state_t {IDLE, RUNNING, PAUSED, LAP}
  - typedef bcd_t (logic [3:0])
  - struct sw_time_t (four bcd_t fields)
  - constants SEC_TENS_MAX=5, MIN_TENS_MAX=5
- Sub-module button_debouncer (synchronizer, counter, accepted level, press pulse; parameter DEBOUNCE_MS), instantiated three times.
- Synchronizer, edge detect, FSM and BCD chain stay in the top module.

Test Plan:
- Reset check: drive 1 kHz, hold rst_n low, then release -> state IDLE, all digits 0, running=0, overflow=0; presses of lap or reset in IDLE leave everything at 0.
- Start and count: TICKS_PER_SEC=10, DEBOUNCE_MS=2. Press start, run 25 ms ticks -> 00:02, running=1. Press start_stop at 5 residual ticks, wait 100 ticks, resume, then 5 more ticks -> 00:03.
- Lap freeze: RUNNING at 00:04, press lap -> lap_active=1 and display frozen at 00:04 while counting continues. After 3 s press lap -> display jumps live to 00:07.
- Debounce: a 1-tick glitch, then 1 stable tick, on start_stop -> no event. A press held 2 stable ticks -> exactly one start event; release generates none.
- Rollover and clear: run to 59:59, then 1 more second -> 00:00, overflow=1. Pause, press reset -> IDLE, 00:00, overflow=0.
- Priority and ignore rules: start_stop and reset pulse in the same cycle while PAUSED -> RUNNING, count retained. Reset while RUNNING -> ignored, count continues.
